// File: rtl/load_store_buffer.sv
// In-order load/store queue: computes effective addresses, issues one memory
// request at a time, broadcasts load results and holds stores until committed.
module load_store_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ls_mission,
    input  logic [3:0]  ls_ins_rnm,
    input  logic [5:0]  ls_op_type,
    input  logic [31:0] ls_addr_offset,
    input  logic [31:0] ls_ins_rs1,
    input  logic [31:0] store_ins_rs2,
    input  logic        store_commit_flag,
    input  logic [3:0]  store_commit_rnm,
    input  logic        rs_flush,
    output logic        lsb_full,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        lsb_result_flag,
    output logic [3:0]  lsb_result_rnm,
    output logic [31:0] lsb_result_value
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [5:0] OP_LB  = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LW  = 6'd13;
    localparam logic [5:0] OP_LBU = 6'd14;
    localparam logic [5:0] OP_LHU = 6'd15;
    localparam logic [5:0] OP_SB  = 6'd16;
    localparam logic [5:0] OP_SH  = 6'd17;
    localparam logic [5:0] OP_SW  = 6'd18;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_cmt;
    logic [DEPTH-1:0]  r_st;
    logic [5:0]        r_op   [DEPTH];
    logic [3:0]        r_rnm  [DEPTH];
    logic [31:0]       r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_head_st;
    logic [5:0]        w_head_op;
    logic [DEPTH-1:0]  w_cmt_next;
    logic [DEPTH-1:0]  w_keep;
    logic [CNT_W-1:0]  w_ncommit;
    logic [1:0]        w_head_width;
    logic [31:0]       w_ext;
    logic              w_in_store;

    assign lsb_full  = (r_count >= CNT_W'(DEPTH - 1));
    assign w_head_st = r_st[r_head];
    assign w_head_op = r_op[r_head];
    assign w_in_store = (ls_op_type == OP_SB) || (ls_op_type == OP_SH) || (ls_op_type == OP_SW);

    // A flushed load still in flight is discarded, so only a completing store pops then.
    assign w_push  = ls_mission && !rs_flush && (r_count != CNT_W'(DEPTH));
    assign w_pop   = (r_state == S_WAIT) && mem_done && (w_head_st || !rs_flush);
    assign w_issue = (r_state == S_IDLE) && (r_count != '0)
                     && (w_head_st ? r_cmt[r_head] : !rs_flush);

    // Commit matching and the committed-prefix length that survives a flush
    always_comb begin
        w_cmt_next = r_cmt;
        w_ncommit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (store_commit_flag && r_vld[i] && r_st[i] && (r_rnm[i] == store_commit_rnm)) begin
                w_cmt_next[i] = 1'b1;
            end
        end
        w_keep = r_vld & w_cmt_next;
        for (int i = 0; i < DEPTH; i++) begin
            w_ncommit = w_ncommit + CNT_W'(w_keep[i]);
        end
    end

    always_comb begin
        w_head_width = 2'd2;
        case (w_head_op)
            OP_LB, OP_LBU, OP_SB: w_head_width = 2'd0;
            OP_LH, OP_LHU, OP_SH: w_head_width = 2'd1;
            default:              w_head_width = 2'd2;
        endcase
    end

    always_comb begin
        w_ext = mem_rdata;
        case (w_head_op)
            OP_LB:   w_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            OP_LBU:  w_ext = {24'd0, mem_rdata[7:0]};
            OP_LH:   w_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            OP_LHU:  w_ext = {16'd0, mem_rdata[15:0]};
            OP_LW:   w_ext = mem_rdata;
            default: w_ext = mem_rdata;
        endcase
    end

    // Queue pointers and per-entry status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_cmt   <= '0;
            r_st    <= '0;
        end else if (rdy) begin
            if (rs_flush) begin
                r_vld  <= w_keep;
                r_cmt  <= w_cmt_next & w_keep;
                r_tail <= r_head + ADDR_W'(w_ncommit);
                if (w_pop) begin
                    r_head         <= r_head + ADDR_W'(1);
                    r_count        <= w_ncommit - CNT_W'(1);
                    r_vld[r_head]  <= 1'b0;
                    r_cmt[r_head]  <= 1'b0;
                end else begin
                    r_count <= w_ncommit;
                end
            end else begin
                r_cmt <= w_cmt_next;
                if (w_pop) begin
                    r_head        <= r_head + ADDR_W'(1);
                    r_vld[r_head] <= 1'b0;
                    r_cmt[r_head] <= 1'b0;
                end
                if (w_push) begin
                    r_tail        <= r_tail + ADDR_W'(1);
                    r_vld[r_tail] <= 1'b1;
                    r_cmt[r_tail] <= 1'b0;
                    r_st[r_tail]  <= w_in_store;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Entry payload; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (rdy && w_push) begin
            r_op[r_tail]   <= ls_op_type;
            r_rnm[r_tail]  <= ls_ins_rnm;
            r_addr[r_tail] <= ls_ins_rs1 + ls_addr_offset;
            r_data[r_tail] <= store_ins_rs2;
        end
    end

    // Memory request FSM and CDB outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_width        <= '0;
            mem_wdata        <= '0;
            lsb_result_flag  <= 1'b0;
            lsb_result_rnm   <= '0;
            lsb_result_value <= '0;
        end else if (rdy) begin
            lsb_result_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        mem_req   <= 1'b1;
                        mem_we    <= w_head_st;
                        mem_addr  <= r_addr[r_head];
                        mem_width <= w_head_width;
                        mem_wdata <= r_data[r_head];
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                        if (!w_head_st && !rs_flush) begin
                            lsb_result_flag  <= 1'b1;
                            lsb_result_rnm   <= r_rnm[r_head];
                            lsb_result_value <= w_ext;
                        end
                    end else if (rs_flush && !w_head_st) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: memory responder with request
// scoreboard, CDB monitor, extension vector table and hand-written corner cases.
module tb_load_store_buffer;

    localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
    localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

    logic        clk = 1'b0;
    logic        rst, rdy, ls_mission, store_commit_flag, rs_flush, mem_done;
    logic [3:0]  ls_ins_rnm, store_commit_rnm;
    logic [5:0]  ls_op_type;
    logic [31:0] ls_addr_offset, ls_ins_rs1, store_ins_rs2, mem_rdata;
    logic        lsb_full, mem_req, mem_we, lsb_result_flag;
    logic [31:0] mem_addr, mem_wdata, lsb_result_value;
    logic [1:0]  mem_width;
    logic [3:0]  lsb_result_rnm;

    load_store_buffer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ls_mission(ls_mission), .ls_ins_rnm(ls_ins_rnm), .ls_op_type(ls_op_type),
        .ls_addr_offset(ls_addr_offset), .ls_ins_rs1(ls_ins_rs1), .store_ins_rs2(store_ins_rs2),
        .store_commit_flag(store_commit_flag), .store_commit_rnm(store_commit_rnm),
        .rs_flush(rs_flush), .lsb_full(lsb_full),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .lsb_result_flag(lsb_result_flag), .lsb_result_rnm(lsb_result_rnm),
        .lsb_result_value(lsb_result_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        cdb;
    } req_t;

    typedef struct {
        logic [3:0]  rnm;
        logic [31:0] value;
    } cdb_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] off;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [1:0]  exp_w;
        logic [31:0] exp_val;
    } vec_t;

    req_t req_q[$];
    cdb_t cdb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stall   = 1'b0;
    int   lat     = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] width_of(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 2'd0;
        if (op == LH || op == LHU || op == SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] ext_of(input logic [5:0] op, input logic [31:0] d);
        case (op)
            LB:      return {{24{d[7]}}, d[7:0]};
            LBU:     return {24'd0, d[7:0]};
            LH:      return {{16{d[15]}}, d[15:0]};
            LHU:     return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Memory responder: checks each request against the scoreboard, then completes it
    initial begin
        req_t r;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !stall && rst === 1'b0) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                    r.rdata = '0;
                    r.cdb   = 1'b0;
                    r.addr  = mem_addr;
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", mem_addr, r.addr);
                    chk("req_we", 32'(mem_we), 32'(r.we));
                    chk("req_width", 32'(mem_width), 32'(r.width));
                    if (r.we) chk("req_wdata", mem_wdata, r.wdata);
                end
                repeat (lat) @(negedge clk);
                chk("req_hold", 32'(mem_req), 32'd1);
                chk("req_hold_addr", mem_addr, r.addr);
                mem_done  = 1'b1;
                mem_rdata = r.rdata;
                @(negedge clk);
                mem_done  = 1'b0;
                mem_rdata = '0;
                chk("req_drop", 32'(mem_req), 32'd0);
                chk("cdb_timing", 32'(lsb_result_flag), 32'(r.cdb));
            end
        end
    end

    // CDB monitor: every broadcast must match the oldest expected load result
    initial begin
        cdb_t c;
        forever begin
            @(negedge clk);
            if (lsb_result_flag === 1'b1) begin
                if (cdb_q.size() == 0) begin
                    chk("unexpected_cdb", 32'(lsb_result_flag), 32'd0);
                end else begin
                    c = cdb_q.pop_front();
                    chk("cdb_rnm", 32'(lsb_result_rnm), 32'(c.rnm));
                    chk("cdb_value", lsb_result_value, c.value);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time %0t exceeded the 1 ms limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_op(input logic [5:0] op, input logic [3:0] rnm, input logic [31:0] rs1,
                           input logic [31:0] off, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [31:0] exp_addr, input logic [1:0] exp_w,
                           input logic [31:0] exp_val, input bit exp_req, input bit exp_cdb);
        req_t r;
        cdb_t c;
        int   t = 0;
        while (lsb_full && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("full_timeout", 32'(lsb_full), 32'd0);
        if (exp_req) begin
            r.addr  = exp_addr;
            r.we    = (op >= SB);
            r.width = exp_w;
            r.wdata = wd;
            r.rdata = rd;
            r.cdb   = exp_cdb && (op < SB);
            req_q.push_back(r);
            if (r.cdb) begin
                c.rnm   = rnm;
                c.value = exp_val;
                cdb_q.push_back(c);
            end
        end
        ls_mission     = 1'b1;
        ls_op_type     = op;
        ls_ins_rnm     = rnm;
        ls_ins_rs1     = rs1;
        ls_addr_offset = off;
        store_ins_rs2  = wd;
        @(negedge clk);
        ls_mission     = 1'b0;
    endtask

    task automatic push_auto(input logic [5:0] op, input logic [3:0] rnm, input logic [31:0] rs1,
                             input logic [31:0] off, input logic [31:0] wd, input logic [31:0] rd,
                             input bit exp_req, input bit exp_cdb);
        push_op(op, rnm, rs1, off, wd, rd, rs1 + off, width_of(op), ext_of(op, rd), exp_req, exp_cdb);
    endtask

    task automatic commit(input logic [3:0] rnm);
        store_commit_flag = 1'b1;
        store_commit_rnm  = rnm;
        @(negedge clk);
        store_commit_flag = 1'b0;
    endtask

    task automatic flush();
        rs_flush = 1'b1;
        @(negedge clk);
        rs_flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((req_q.size() != 0 || cdb_q.size() != 0 || mem_req) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(req_q.size()) + 32'(cdb_q.size()) + 32'(mem_req), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req();
        int t = 0;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_seen", 32'(mem_req), 32'd1);
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mem_req) hi++;
        end
        chk(name, 32'(hi), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   hi;
        vecs[0] = '{LW,  32'h0000_1000, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_1010, 2'd2, 32'hDEAD_BEEF};
        vecs[1] = '{LB,  32'h0000_2000, 32'h0000_0004, 32'h0000_00F0, 32'h0000_2004, 2'd0, 32'hFFFF_FFF0};
        vecs[2] = '{LBU, 32'h0000_2000, 32'h0000_0005, 32'h0000_00F0, 32'h0000_2005, 2'd0, 32'h0000_00F0};
        vecs[3] = '{LH,  32'h0000_3000, 32'h0000_0002, 32'h0000_8001, 32'h0000_3002, 2'd1, 32'hFFFF_8001};
        vecs[4] = '{LHU, 32'h0000_3000, 32'h0000_0002, 32'h0000_8001, 32'h0000_3002, 2'd1, 32'h0000_8001};
        vecs[5] = '{LH,  32'h0000_0100, 32'hFFFF_FFF0, 32'h1234_7FFF, 32'h0000_00F0, 2'd1, 32'h0000_7FFF};
        vecs[6] = '{LW,  32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0000, 32'h0000_0004, 2'd2, 32'h0000_0000};
        vecs[7] = '{LB,  32'h0000_4000, 32'h0000_0000, 32'hABCD_EF7F, 32'h0000_4000, 2'd0, 32'h0000_007F};

        rst = 1'b1; rdy = 1'b1; ls_mission = 1'b0; store_commit_flag = 1'b0; rs_flush = 1'b0;
        ls_ins_rnm = '0; store_commit_rnm = '0; ls_op_type = '0;
        ls_addr_offset = '0; ls_ins_rs1 = '0; store_ins_rs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_width", 32'(mem_width), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cdb_flag", 32'(lsb_result_flag), 32'd0);
        chk("rst_cdb_rnm", 32'(lsb_result_rnm), 32'd0);
        chk("rst_cdb_value", lsb_result_value, 32'd0);
        chk("rst_full", 32'(lsb_full), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW round trip with exact issue latency
        push_op(LW, 4'd1, 32'h1000, 32'h10, 32'd0, 32'hDEAD_BEEF, 32'h1010, 2'd2, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("issue_lat_edge_n", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("issue_lat_edge_n1", 32'(mem_req), 32'd1);
        wait_drain("lw_round_trip");

        // Address and extension vectors
        for (int i = 0; i < 8; i++) begin
            push_op(vecs[i].op, 4'(i), vecs[i].rs1, vecs[i].off, 32'd0, vecs[i].rdata,
                    vecs[i].exp_addr, vecs[i].exp_w, vecs[i].exp_val, 1'b1, 1'b1);
            wait_drain("vector_drain");
        end

        // Store held until its own tag commits
        push_auto(SW, 4'd5, 32'h4000, 32'h8, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        quiet_window("store_gated", 5);
        commit(4'd6);
        quiet_window("store_gated_wrong_tag", 5);
        commit(4'd5);
        @(negedge clk);
        chk("store_issue", 32'(mem_req), 32'd1);
        chk("store_we", 32'(mem_we), 32'd1);
        chk("store_wdata", mem_wdata, 32'h1234_5678);
        wait_drain("store_drain");

        // Fill to the full threshold with memory stalled, then wrap the indices
        stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_auto(LW, 4'(i), 32'h500, 32'(4 * i), 32'd0, 32'h1000 + 32'(i), 1'b1, 1'b1);
            if (i == 5) chk("full_at_6", 32'(lsb_full), 32'd0);
        end
        chk("full_at_7", 32'(lsb_full), 32'd1);
        stall = 1'b0;
        lat   = 1;
        wait_drain("full_drain");
        for (int i = 0; i < 8; i++) begin
            push_auto(LW, 4'(7 + i), 32'h600, 32'(4 * i), 32'd0, 32'hA000 + 32'(i), 1'b1, 1'b1);
        end
        wait_drain("wrap_drain");
        lat = 3;

        // Flush keeps only the committed store at head
        stall = 1'b1;
        push_auto(SW, 4'd1, 32'h700, 32'd0, 32'hCAFE_0001, 32'd0, 1'b1, 1'b0);
        commit(4'd1);
        push_auto(SW, 4'd2, 32'h704, 32'd0, 32'hCAFE_0002, 32'd0, 1'b0, 1'b0);
        push_auto(LB, 4'd3, 32'h708, 32'd0, 32'd0, 32'h80, 1'b0, 1'b0);
        flush();
        for (int i = 0; i < 6; i++) begin
            push_auto(LW, 4'(8 + i), 32'h800, 32'(4 * i), 32'd0, 32'hB000 + 32'(i), 1'b1, 1'b1);
            if (i == 4) chk("flush_count_full_lo", 32'(lsb_full), 32'd0);
        end
        chk("flush_count_full_hi", 32'(lsb_full), 32'd1);
        stall = 1'b0;
        wait_drain("flush_drain");
        quiet_window("flush_no_extra_req", 10);

        // Flush while a load is in flight: data dropped, FSM recovers
        stall = 1'b1;
        push_auto(LB, 4'd4, 32'h900, 32'd1, 32'd0, 32'hFF, 1'b1, 1'b0);
        wait_req();
        flush();
        repeat (2) @(negedge clk);
        stall = 1'b0;
        wait_drain("inflight_flush_drain");
        push_auto(LH, 4'd5, 32'h900, 32'd2, 32'd0, 32'h8001, 1'b1, 1'b1);
        wait_drain("after_inflight_flush");

        // Asynchronous reset during an outstanding request
        stall = 1'b1;
        push_auto(LW, 4'd6, 32'hA00, 32'd0, 32'd0, 32'd1, 1'b1, 1'b1);
        wait_req();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_full", 32'(lsb_full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_q.delete();
        cdb_q.delete();
        stall = 1'b0;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req || lsb_result_flag) hi++;
        end
        chk("post_rst_quiet", 32'(hi), 32'd0);
        push_auto(LBU, 4'd7, 32'hB00, 32'd3, 32'd0, 32'h0000_00F0, 1'b1, 1'b1);
        wait_drain("post_rst_load");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
